// File: rtl/riscv_alu.sv
// RV32IM execute-stage ALU: base integer plus M-extension ops, with a registered
// result and zero flag for writeback and branch resolution.
module riscv_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ip1,
    input  logic [WIDTH-1:0] ip2,
    input  logic [6:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned W2 = 2 * WIDTH;

    localparam logic [6:0] OP_ADD    = 7'd0;
    localparam logic [6:0] OP_SUB    = 7'd1;
    localparam logic [6:0] OP_SLL    = 7'd2;
    localparam logic [6:0] OP_SLT    = 7'd3;
    localparam logic [6:0] OP_SLTU   = 7'd4;
    localparam logic [6:0] OP_XOR    = 7'd5;
    localparam logic [6:0] OP_SRL    = 7'd6;
    localparam logic [6:0] OP_SRA    = 7'd7;
    localparam logic [6:0] OP_OR     = 7'd8;
    localparam logic [6:0] OP_AND    = 7'd9;
    localparam logic [6:0] OP_MUL    = 7'd10;
    localparam logic [6:0] OP_MULH   = 7'd11;
    localparam logic [6:0] OP_MULHSU = 7'd12;
    localparam logic [6:0] OP_MULHU  = 7'd13;
    localparam logic [6:0] OP_DIV    = 7'd14;
    localparam logic [6:0] OP_DIVU   = 7'd15;
    localparam logic [6:0] OP_REM    = 7'd16;
    localparam logic [6:0] OP_REMU   = 7'd17;

    logic [W-1:0]  result_d, result_q;
    logic          zero_d, zero_q;
    logic [4:0]    shamt;
    logic          mul_a_sgn, mul_b_sgn;
    logic [W2-1:0] mul_a, mul_b, product;
    logic          div_signed, a_neg, b_neg;
    logic [W-1:0]  abs_a, abs_b, divisor, quot, rem, quot_s, rem_s;

    assign shamt = ip2[4:0];

    // One shared multiplier: operands sign- or zero-extended to 2W per op flavour
    always_comb begin
        mul_a_sgn = (operation == OP_MULH) || (operation == OP_MULHSU);
        mul_b_sgn = (operation == OP_MULH);
        mul_a     = {{W{mul_a_sgn & ip1[W-1]}}, ip1};
        mul_b     = {{W{mul_b_sgn & ip2[W-1]}}, ip2};
        product   = mul_a * mul_b;
    end

    // Sign-magnitude divide; the overflow case falls out as 0x80000000 / rem 0
    always_comb begin
        div_signed = (operation == OP_DIV) || (operation == OP_REM);
        a_neg      = div_signed & ip1[W-1];
        b_neg      = div_signed & ip2[W-1];
        abs_a      = a_neg ? (~ip1 + W'(1)) : ip1;
        abs_b      = b_neg ? (~ip2 + W'(1)) : ip2;
        divisor    = (ip2 == '0) ? W'(1) : abs_b;
        quot       = abs_a / divisor;
        rem        = abs_a % divisor;
        quot_s     = (a_neg ^ b_neg) ? (~quot + W'(1)) : quot;
        rem_s      = a_neg ? (~rem + W'(1)) : rem;
    end

    always_comb begin
        result_d = '0;
        case (operation)
            OP_ADD:    result_d = ip1 + ip2;
            OP_SUB:    result_d = ip1 - ip2;
            OP_SLL:    result_d = ip1 << shamt;
            OP_SLT:    result_d = {{(W-1){1'b0}}, ($signed(ip1) < $signed(ip2))};
            OP_SLTU:   result_d = {{(W-1){1'b0}}, (ip1 < ip2)};
            OP_XOR:    result_d = ip1 ^ ip2;
            OP_SRL:    result_d = ip1 >> shamt;
            OP_SRA:    result_d = $signed(ip1) >>> shamt;
            OP_OR:     result_d = ip1 | ip2;
            OP_AND:    result_d = ip1 & ip2;
            OP_MUL:    result_d = product[W-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  result_d = product[W2-1:W];
            OP_DIV,
            OP_DIVU:   result_d = (ip2 == '0) ? '1 : quot_s;
            OP_REM,
            OP_REMU:   result_d = (ip2 == '0) ? ip1 : rem_s;
            default:   result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result    = result_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_riscv_alu.sv
// Scoreboard bench for riscv_alu: directed corner cases plus randomised ops
// checked against a behavioural reference model.
module tb_riscv_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ip1, ip2;
    logic [6:0]  operation;
    logic [31:0] result;
    logic        zero_flag;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    riscv_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ip1       (ip1),
        .ip2       (ip2),
        .operation (operation),
        .result    (result),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            7'd0:  return a + b;
            7'd1:  return a - b;
            7'd2:  return a << b[4:0];
            7'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7'd4:  return (a < b) ? 32'd1 : 32'd0;
            7'd5:  return a ^ b;
            7'd6:  return a >> b[4:0];
            7'd7:  return 32'($signed(a) >>> b[4:0]);
            7'd8:  return a | b;
            7'd9:  return a & b;
            7'd10: begin p = 64'(sa * sb); return p[31:0]; end
            7'd11: begin p = 64'(sa * sb); return p[63:32]; end
            7'd12: begin p = 64'(sa * ub); return p[63:32]; end
            7'd13: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            7'd14: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            7'd15: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            7'd16: return (b == 32'd0) ? a : 32'(sa % sb);
            7'd17: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input string tag, input logic [6:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        operation = op;
        ip1       = a;
        ip2       = b;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    // Each driven op must show up exactly one rising edge later
    always @(posedge clk) begin
        logic [31:0] e;
        string       t;
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, result, e);
            check({t, "_zf"}, {31'b0, zero_flag}, {31'b0, (e == 32'd0)});
        end
    end

    initial begin
        logic [6:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; ip1 = 32'h1234_5678; ip2 = 32'h9; operation = 7'd0;
        #1;
        check("rst_res", result, 32'd0);
        check("rst_zf", {31'b0, zero_flag}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        drive("add",     7'd0,  32'd23, 32'd46, 32'd69);
        drive("sub",     7'd1,  32'd128, 32'd59, 32'd69);
        drive("sll",     7'd2,  32'd23, 32'd2, 32'd92);
        drive("remu",    7'd17, 32'd654, 32'd46, 32'd10);
        drive("and",     7'd9,  32'd1, 32'd1, 32'd1);
        drive("or",      7'd8,  32'd0, 32'd1, 32'd1);
        drive("xor",     7'd5,  32'd1, 32'd1, 32'd0);
        drive("sra",     7'd7,  32'h8000_0000, 32'd4, 32'hF800_0000);
        drive("srl",     7'd6,  32'h8000_0000, 32'd4, 32'h0800_0000);
        drive("slt",     7'd3,  32'hFFFF_FFFF, 32'd1, 32'd1);
        drive("sltu",    7'd4,  32'hFFFF_FFFF, 32'd1, 32'd0);
        drive("sll33",   7'd2,  32'd1, 32'd33, 32'd2);
        drive("mulhu",   7'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        drive("div0",    7'd14, 32'd7, 32'd0, 32'hFFFF_FFFF);
        drive("rem0",    7'd16, 32'd7, 32'd0, 32'd7);
        drive("divovf",  7'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        drive("removf",  7'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        drive("divneg",  7'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        drive("remneg",  7'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        drive("mul",     7'd10, 32'd6, 32'd7, 32'd42);
        drive("mulh",    7'd11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        drive("mulhsu",  7'd12, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
        drive("mulhu2",  7'd13, 32'hFFFF_FFFF, 32'd2, 32'd1);
        drive("divu",    7'd15, 32'd100, 32'd7, 32'd14);
        drive("divu0",   7'd15, 32'd100, 32'd0, 32'hFFFF_FFFF);
        drive("undef",   7'd100, 32'd5, 32'd9, 32'd0);
        drive("pre_rst", 7'd0,  32'd23, 32'd46, 32'd69);

        // Reset mid-stream, between edges, with a nonzero result in the register
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid_res", result, 32'd0);
        check("rst_mid_zf", {31'b0, zero_flag}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_hold_res", result, 32'd0);
        check("rst_hold_zf", {31'b0, zero_flag}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive("post_rst", 7'd1, 32'd10, 32'd3, 32'd7);

        for (int i = 0; i < 80; i++) begin
            op = 7'($urandom_range(0, 19));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(0, 40);
                3: a = 32'h8000_0000;
                default: ;
            endcase
            drive("rnd", op, a, b, ref_alu(op, a, b));
        end

        repeat (4) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
